// File: rtl/misaligned_lsu_pkg.sv
// Shared types and constants for the misaligned load/store sequencer.
//   state_t     : sequencer FSM states
//   size_t      : access size class decoded from Funct3
//   F3_*        : Funct3 encodings for loads/stores
//   last_index  : index of the final byte of a split access
package lsu_pkg;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_PASS   // 011/110/111: forwarded untouched, never split
  } size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [1:0] last_index(input size_t s);
    return (s == SZ_HALF) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/misaligned_lsu_if.sv
// Bus bundle between the MEM-stage pipeline, the sequencer and data memory.
//   master : pipeline/memory environment (drives request fields and dm_rd)
//   slave  : the sequencer (drives dm_* strobes, stall and load result)
interface misaligned_lsu_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     dm_rd;
  logic                  dm_MemRead;
  logic                  dm_MemWrite;
  logic [DM_ADDRESS-1:0] dm_a;
  logic [DATA_W-1:0]     dm_wd;
  logic [2:0]            dm_Funct3;
  logic                  stall;
  logic                  ld_valid;
  logic [DATA_W-1:0]     ld_data;

  modport master (
    output req_valid, MemRead, MemWrite, Funct3, addr, wdata, dm_rd,
    input  dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3, stall, ld_valid, ld_data
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wdata, dm_rd,
    output dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3, stall, ld_valid, ld_data
  );
endinterface

// File: rtl/misaligned_lsu_align_check.sv
// Combinational size/alignment decode of a load/store.
//   funct3      : instruction bits 14:12
//   addr_lo     : byte address bits 1:0
//   size        : byte/half/word or pass-through class
//   misaligned  : halfword on odd address, or word not on a 4-byte boundary
//   is_unsigned : LBU/LHU style zero extension
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output size_t      size,
  output logic       misaligned,
  output logic       is_unsigned
);

  always_comb begin
    size        = SZ_PASS;
    misaligned  = 1'b0;
    is_unsigned = funct3[2];
    unique case (funct3)
      3'b000, 3'b100: size = SZ_BYTE;
      3'b001, 3'b101: begin
        size       = SZ_HALF;
        misaligned = addr_lo[0];
      end
      3'b010: begin
        size       = SZ_WORD;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/misaligned_lsu.sv
// MEM-stage load/store sequencer.
// Aligned accesses pass straight to data memory in one cycle; misaligned
// halfword/word accesses are split into LBU/SB byte accesses while the
// pipeline is stalled. Aligned LHU is performed as LW plus local extraction.
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : request fields in, data-memory strobes/address/data out,
//                stall and load result (ld_valid/ld_data) out
module misaligned_lsu
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic           clk,
  input  logic           reset,
  misaligned_lsu_if.slave bus
);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  size_t                 size_q;
  logic                  uns_q;
  logic                  read_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [23:0]           cap_q;

  size_t                 size;
  logic                  misal;
  logic                  is_uns;
  logic                  req;
  logic                  accept;
  logic                  last;
  logic [15:0]           hval;

  logic                  dm_rd_c, dm_wr_c;
  logic [DM_ADDRESS-1:0] dm_a_c;
  logic [DATA_W-1:0]     dm_wd_c;
  logic [2:0]            dm_f3_c;
  logic                  stall_c, ldv_c;
  logic [DATA_W-1:0]     ldd_c;

  lsu_align_check u_align_check (
    .funct3      (bus.Funct3),
    .addr_lo     (bus.addr[1:0]),
    .size        (size),
    .misaligned  (misal),
    .is_unsigned (is_uns)
  );

  assign req    = bus.req_valid & (bus.MemRead | bus.MemWrite);
  assign accept = (state_q == IDLE) & req & misal;
  assign last   = (state_q == SPLIT) & (cnt_q == last_index(size_q));
  assign hval   = {bus.dm_rd[7:0], cap_q[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        size_q  <= size;
        uns_q   <= is_uns;
        read_q  <= bus.MemRead;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        if (bus.MemRead) cap_q[7:0] <= bus.dm_rd[7:0];
      end else if ((state_q == SPLIT) && read_q && !last) begin
        // Final byte is never buffered; it is merged straight from dm_rd.
        unique case (cnt_q)
          2'd1:    cap_q[15:8]  <= bus.dm_rd[7:0];
          2'd2:    cap_q[23:16] <= bus.dm_rd[7:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dm_rd_c = 1'b0;
    dm_wr_c = 1'b0;
    dm_a_c  = bus.addr;
    dm_wd_c = bus.wdata;
    dm_f3_c = bus.Funct3;
    stall_c = 1'b0;
    ldv_c   = 1'b0;
    ldd_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (misal) begin
            dm_rd_c      = bus.MemRead;
            dm_wr_c      = ~bus.MemRead;
            dm_f3_c      = bus.MemRead ? F3_LBU : F3_SB;
            dm_wd_c      = '0;
            dm_wd_c[7:0] = bus.wdata[7:0];
            stall_c      = 1'b1;
            state_d      = SPLIT;
            cnt_d        = 2'd1;
          end else begin
            dm_rd_c = bus.MemRead;
            dm_wr_c = bus.MemWrite & ~bus.MemRead;
            if (bus.MemRead) begin
              ldv_c = 1'b1;
              ldd_c = bus.dm_rd;
              // LHU is served as a word read; the halfword is picked here.
              if (bus.Funct3 == F3_LHU) begin
                dm_f3_c = F3_LW;
                ldd_c   = {16'b0, bus.addr[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0]};
              end
            end
          end
        end
      end
      SPLIT: begin
        dm_a_c       = addr_q + {{(DM_ADDRESS-2){1'b0}}, cnt_q};
        dm_rd_c      = read_q;
        dm_wr_c      = ~read_q;
        dm_f3_c      = read_q ? F3_LBU : F3_SB;
        dm_wd_c      = '0;
        dm_wd_c[7:0] = wdata_q[{cnt_q, 3'b000} +: 8];
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (read_q) begin
            ldv_c = 1'b1;
            if (size_q == SZ_HALF)
              ldd_c = uns_q ? {16'b0, hval} : {{16{hval[15]}}, hval};
            else
              ldd_c = {bus.dm_rd[7:0], cap_q};
          end
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      dm_rd_c = 1'b0;
      dm_wr_c = 1'b0;
      stall_c = 1'b0;
      ldv_c   = 1'b0;
      ldd_c   = '0;
    end
  end

  assign bus.dm_MemRead  = dm_rd_c;
  assign bus.dm_MemWrite = dm_wr_c;
  assign bus.dm_a        = dm_a_c;
  assign bus.dm_wd       = dm_wd_c;
  assign bus.dm_Funct3   = dm_f3_c;
  assign bus.stall       = stall_c;
  assign bus.ld_valid    = ldv_c;
  assign bus.ld_data     = ldd_c;

endmodule

// File: tb/tb_misaligned_lsu.sv
// Scoreboard bench for misaligned_lsu: a byte-array reference model predicts
// each cycle's memory access and load result; a monitor checks the DUT.
module tb_misaligned_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  misaligned_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  misaligned_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [8:0]  a;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic        stall;
    logic        ldv;
    logic [31:0] ldd;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem[512];
  logic [7:0]  ref_mem[512];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_ld;
  logic [8:0]  ha, wa;

  // Data memory: combinational read, write on falling edge.
  always @* begin
    ha = {bus.dm_a[8:1], 1'b0};
    wa = {bus.dm_a[8:2], 2'b00};
    case (bus.dm_Funct3)
      3'b000:  bus.dm_rd = {{24{mem[bus.dm_a][7]}}, mem[bus.dm_a]};
      3'b100:  bus.dm_rd = {24'b0, mem[bus.dm_a]};
      3'b001:  bus.dm_rd = {{16{mem[ha+9'd1][7]}}, mem[ha+9'd1], mem[ha]};
      3'b101:  bus.dm_rd = {16'b0, mem[ha+9'd1], mem[ha]};
      default: bus.dm_rd = {mem[wa+9'd3], mem[wa+9'd2], mem[wa+9'd1], mem[wa]};
    endcase
  end

  always @(negedge clk) begin
    if (bus.dm_MemWrite) begin
      case (bus.dm_Funct3)
        3'b000, 3'b100: mem[bus.dm_a] = bus.dm_wd[7:0];
        3'b001, 3'b101: begin
          mem[{bus.dm_a[8:1], 1'b0}]      = bus.dm_wd[7:0];
          mem[{bus.dm_a[8:1], 1'b0} + 9'd1] = bus.dm_wd[15:8];
        end
        3'b010: for (int i = 0; i < 4; i++)
          mem[{bus.dm_a[8:2], 2'b00} + 9'(i)] = bus.dm_wd[8*i +: 8];
        default: ;
      endcase
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic poke(input logic [8:0] a, input logic [7:0] b);
    mem[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic poke_word(input logic [8:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) poke(a + 9'(i), w[8*i +: 8]);
  endtask

  task automatic zero_mem();
    for (int i = 0; i < 512; i++) poke(9'(i), 8'h00);
  endtask

  // Reference model: predicts the per-cycle access stream from the rules for
  // size, alignment and little-endian byte order; updates ref_mem on stores.
  task automatic model(input logic rv, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    int          nb;
    bit          split;
    logic [31:0] v;
    logic [8:0]  ak;
    exp_t        e;
    if (!rv || (!mr && !mw)) return;
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    split = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    v = 32'h0;
    if (mr) begin
      if (nb == 0) begin
        ak = {a[8:2], 2'b00};
        v = {ref_mem[ak+9'd3], ref_mem[ak+9'd2], ref_mem[ak+9'd1], ref_mem[ak]};
      end else begin
        for (int i = 0; i < nb; i++) begin
          ak = a + 9'(i);
          v[8*i +: 8] = ref_mem[ak];
        end
        if (nb == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
        if (nb == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
      end
    end
    if (split) begin
      for (int k = 0; k < nb; k++) begin
        e.a     = a + 9'(k);
        e.rd    = mr;
        e.wr    = !mr;
        e.f3    = mr ? 3'b100 : 3'b000;
        e.wd    = {24'b0, wd[8*k +: 8]};
        e.stall = (k != nb - 1);
        e.ldv   = mr && (k == nb - 1);
        e.ldd   = e.ldv ? v : 32'h0;
        q.push_back(e);
      end
    end else begin
      e.a     = a;
      e.rd    = mr;
      e.wr    = !mr;
      e.f3    = (mr && f3 == 3'b101) ? 3'b010 : f3;
      e.wd    = wd;
      e.stall = 1'b0;
      e.ldv   = mr;
      e.ldd   = mr ? v : 32'h0;
      q.push_back(e);
    end
    if (!mr && nb > 0)
      for (int i = 0; i < nb; i++) ref_mem[a + 9'(i)] = wd[8*i +: 8];
  endtask

  // Issue one request (called at posedge+1), hold until stall drops.
  task automatic xact(input logic rv, input logic mr, input logic mw,
                      input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    logic s;
    model(rv, mr, mw, f3, a, wd);
    bus.req_valid = rv;
    bus.MemRead   = mr;
    bus.MemWrite  = mw;
    bus.Funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #2;
      s = bus.stall;
      @(posedge clk); #1;
      if (!s) return;
      // Inputs are ignored while splitting; scramble them to prove it.
      bus.req_valid = 1'($urandom);
      bus.MemRead   = 1'($urandom);
      bus.MemWrite  = 1'($urandom);
      bus.Funct3    = 3'($urandom);
      bus.addr      = 9'($urandom);
      bus.wdata     = $urandom;
    end
    chk("stall_timeout", 32'(s), 32'h0);
  endtask

  task automatic dir_load(input string nm, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] exp);
    last_ld = 32'hxxxxxxxx;
    xact(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
    chk(nm, last_ld, exp);
  endtask

  // Monitor: pops one expected record whenever the DUT shows activity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        if (!bus.ld_valid) chk("ld_data_idle_zero", bus.ld_data, 32'h0);
        if (bus.dm_MemRead || bus.dm_MemWrite || bus.stall || bus.ld_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_activity", {bus.dm_MemRead, bus.dm_MemWrite, bus.stall, bus.ld_valid}, 32'h0);
          end else begin
            e = q.pop_front();
            chk("dm_a", 32'(bus.dm_a), 32'(e.a));
            chk("dm_MemRead", 32'(bus.dm_MemRead), 32'(e.rd));
            chk("dm_MemWrite", 32'(bus.dm_MemWrite), 32'(e.wr));
            chk("dm_Funct3", 32'(bus.dm_Funct3), 32'(e.f3));
            if (e.wr) chk("dm_wd", bus.dm_wd, e.wd);
            chk("stall", 32'(bus.stall), 32'(e.stall));
            chk("ld_valid", 32'(bus.ld_valid), 32'(e.ldv));
            chk("ld_data", bus.ld_data, e.ldd);
            if (bus.ld_valid) last_ld = bus.ld_data;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [2:0] f3;
    logic [8:0] a;
    logic mr, mw, rv;

    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.Funct3    = 3'b010;
    bus.addr      = 9'h001;
    bus.wdata     = 32'h0;
    zero_mem();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_ld_valid", 32'(bus.ld_valid), 32'h0);
    chk("rst_ld_data", bus.ld_data, 32'h0);
    chk("rst_dm_MemRead", 32'(bus.dm_MemRead), 32'h0);
    chk("rst_dm_MemWrite", 32'(bus.dm_MemWrite), 32'h0);
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    @(posedge clk); #1;

    // Aligned LW
    poke_word(9'h010, 32'hDEADBEEF);
    dir_load("lw_aligned", 3'b010, 9'h010, 32'hDEADBEEF);

    // Misaligned SW then readback
    zero_mem();
    xact(1'b1, 1'b0, 1'b1, 3'b010, 9'h005, 32'h11223344);
    dir_load("sw_mis_lo", 3'b010, 9'h004, 32'h22334400);
    dir_load("sw_mis_hi", 3'b010, 9'h008, 32'h00000011);

    // Misaligned LH / LHU
    poke(9'h003, 8'h34);
    poke(9'h004, 8'h92);
    dir_load("lh_mis", 3'b001, 9'h003, 32'hFFFF9234);
    dir_load("lhu_mis", 3'b101, 9'h003, 32'h00009234);

    // Aligned LHU upper half
    poke_word(9'h000, 32'h80017F00);
    dir_load("lhu_aligned", 3'b101, 9'h002, 32'h00008001);

    // Address wrap
    poke(9'h1FE, 8'h01);
    poke(9'h1FF, 8'h02);
    poke(9'h000, 8'h03);
    poke(9'h001, 8'h04);
    dir_load("lw_wrap", 3'b010, 9'h1FE, 32'h04030201);

    // Reset during byte k=2 of a misaligned SW
    zero_mem();
    model(1'b1, 1'b0, 1'b1, 3'b010, 9'h001, 32'hAABBCCDD);
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.Funct3    = 3'b010;
    bus.addr      = 9'h001;
    bus.wdata     = 32'hAABBCCDD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    void'(q.pop_back());
    void'(q.pop_back());
    ref_mem[9'h003] = 8'h00;
    ref_mem[9'h004] = 8'h00;
    #1;
    chk("rst_mid_stall", 32'(bus.stall), 32'h0);
    chk("rst_mid_dm_MemWrite", 32'(bus.dm_MemWrite), 32'h0);
    chk("rst_mid_dm_MemRead", 32'(bus.dm_MemRead), 32'h0);
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    dir_load("rst_mid_mem0", 3'b010, 9'h000, 32'h00CCDD00);
    dir_load("rst_mid_mem4", 3'b010, 9'h004, 32'h00000000);

    // Randomized traffic
    for (int i = 0; i < 512; i++) poke(9'(i), 8'($urandom));
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(9, 0) != 0);
      mr = 1'($urandom);
      mw = 1'($urandom);
      f3 = ($urandom_range(7, 0) == 0) ? 3'($urandom) : 3'($urandom_range(2, 0) | ($urandom_range(1, 0) << 2));
      if (f3 == 3'b110) f3 = 3'b010;
      a = ($urandom_range(4, 0) == 0) ? (9'h1FC + 9'($urandom_range(3, 0))) : 9'($urandom);
      xact(rv, mr, mw, f3, a, $urandom);
    end
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image_bad_bytes", 32'(bad), 32'h0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
